// File: rtl/ddr_reset_pkg.sv
// ddr_reset_pkg: shared state encoding and default sizing for the DDR reset sequencer
package ddr_reset_pkg;
   typedef enum logic [1:0] {WAIT_LOCK, COUNT, DONE} state_t;
   localparam int COUNTER_MAX_DEF = 9181;
   localparam int COUNTER_WIDTH_DEF = 16;
endpackage

// File: rtl/sync_2ff.sv
// sync_2ff: two-flop synchroniser for a single asynchronous level, reset to 0
module sync_2ff (
   input  logic clk,
   input  logic rst,
   input  logic d,
   output logic q
);
   (* ASYNC_REG = "TRUE" *) logic s1;
   (* ASYNC_REG = "TRUE" *) logic s2;
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1 <= 1'b0;
         s2 <= 1'b0;
      end else begin
         s1 <= d;
         s2 <= s1;
      end
   end
   assign q = s2;
endmodule

// File: rtl/ddr_reset_ctrl.sv
// ddr_reset_ctrl: holds DDR sys_rst until MMCM lock has been stable for COUNTER_MAX clk_200 cycles
module ddr_reset_ctrl
   import ddr_reset_pkg::*;
#(
   parameter int COUNTER_MAX = COUNTER_MAX_DEF,
   parameter int COUNTER_WIDTH = COUNTER_WIDTH_DEF
) (
   input  logic                     clk_200,
   input  logic                     sys_rst_i,
   input  logic                     mmcm_locked,
   output logic                     sys_rst_o,
   output logic [COUNTER_WIDTH-1:0] debug_counter
);
   if (COUNTER_MAX < 1 || COUNTER_MAX > 2**COUNTER_WIDTH - 1) begin : g_bad_max
      $fatal(1, "ddr_reset_ctrl: COUNTER_MAX out of range for COUNTER_WIDTH");
   end
   localparam logic [COUNTER_WIDTH-1:0] CMAX = COUNTER_WIDTH'(COUNTER_MAX);
   localparam logic [COUNTER_WIDTH-1:0] ONE = COUNTER_WIDTH'(1);
   state_t state;
   logic [COUNTER_WIDTH-1:0] counter;
   logic locked_s;
   sync_2ff u_lock_sync (
      .clk(clk_200),
      .rst(sys_rst_i),
      .d  (mmcm_locked),
      .q  (locked_s)
   );
   // Release is decided on the same edge the count hits CMAX, so COUNTER_MAX=1 skips COUNT entirely
   always_ff @(posedge clk_200 or posedge sys_rst_i) begin
      if (sys_rst_i) begin
         state     <= WAIT_LOCK;
         counter   <= '0;
         sys_rst_o <= 1'b1;
      end else begin
         case (state)
            WAIT_LOCK: if (locked_s) begin
               counter   <= ONE;
               state     <= (CMAX == ONE) ? DONE : COUNT;
               sys_rst_o <= CMAX != ONE;
            end
            COUNT: if (!locked_s) begin
               state     <= WAIT_LOCK;
               counter   <= '0;
               sys_rst_o <= 1'b1;
            end else begin
               counter <= counter + ONE;
               if (counter + ONE == CMAX) begin
                  state     <= DONE;
                  sys_rst_o <= 1'b0;
               end
            end
            DONE: if (!locked_s) begin
               state     <= WAIT_LOCK;
               counter   <= '0;
               sys_rst_o <= 1'b1;
            end
            default: begin
               state     <= WAIT_LOCK;
               counter   <= '0;
               sys_rst_o <= 1'b1;
            end
         endcase
      end
   end
   assign debug_counter = counter;
endmodule

// File: tb/tb_ddr_reset_ctrl.sv
// tb_ddr_reset_ctrl: random lock/reset stimulus against a lock-run-length reference model
`timescale 1ns/1ps
module tb_ddr_reset_ctrl;
   logic clk_200 = 1'b0;
   logic sys_rst_i = 1'b0;
   logic mmcm_locked = 1'b0;
   logic mon_en = 1'b0;
   logic r16, r1, rdef, r255, rbig;
   logic [15:0] c16, c1, cdef, cbig;
   logic [7:0] c255;
   int n_checks = 0;
   int n_fail = 0;
   ddr_reset_ctrl #(.COUNTER_MAX(16), .COUNTER_WIDTH(16)) u16 (
      .clk_200(clk_200), .sys_rst_i(sys_rst_i), .mmcm_locked(mmcm_locked),
      .sys_rst_o(r16), .debug_counter(c16));
   ddr_reset_ctrl #(.COUNTER_MAX(1), .COUNTER_WIDTH(16)) u1 (
      .clk_200(clk_200), .sys_rst_i(sys_rst_i), .mmcm_locked(mmcm_locked),
      .sys_rst_o(r1), .debug_counter(c1));
   ddr_reset_ctrl udef (
      .clk_200(clk_200), .sys_rst_i(sys_rst_i), .mmcm_locked(mmcm_locked),
      .sys_rst_o(rdef), .debug_counter(cdef));
   ddr_reset_ctrl #(.COUNTER_MAX(255), .COUNTER_WIDTH(8)) u255 (
      .clk_200(clk_200), .sys_rst_i(sys_rst_i), .mmcm_locked(mmcm_locked),
      .sys_rst_o(r255), .debug_counter(c255));
   ddr_reset_ctrl #(.COUNTER_MAX(65535), .COUNTER_WIDTH(16)) ubig (
      .clk_200(clk_200), .sys_rst_i(sys_rst_i), .mmcm_locked(mmcm_locked),
      .sys_rst_o(rbig), .debug_counter(cbig));
   always #2.5 clk_200 = ~clk_200;
   // Reference: lock is seen two edges late; count = consecutive seen-high edges, capped at N
   logic [1:0] seen_q = 2'b00;
   int run = 0;
   always @(posedge clk_200 or posedge sys_rst_i) begin
      if (sys_rst_i) begin
         seen_q <= 2'b00;
         run    <= 0;
      end else begin
         seen_q <= {seen_q[0], mmcm_locked};
         run    <= seen_q[1] ? run + 1 : 0;
      end
   end
   function automatic int exp_cnt(int n);
      return run < n ? run : n;
   endfunction
   function automatic int exp_rst(int n);
      return run < n ? 1 : 0;
   endfunction
   task automatic check(string tag, int got, int exp);
      n_checks++;
      if (got != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
      end
   endtask
   task automatic check_all(string p);
      check({p, "_rst16"}, int'(r16), exp_rst(16));
      check({p, "_cnt16"}, int'(c16), exp_cnt(16));
      check({p, "_rst1"}, int'(r1), exp_rst(1));
      check({p, "_cnt1"}, int'(c1), exp_cnt(1));
      check({p, "_rstdef"}, int'(rdef), exp_rst(9181));
      check({p, "_cntdef"}, int'(cdef), exp_cnt(9181));
      check({p, "_rst255"}, int'(r255), exp_rst(255));
      check({p, "_cnt255"}, int'(c255), exp_cnt(255));
      check({p, "_rstbig"}, int'(rbig), exp_rst(65535));
      check({p, "_cntbig"}, int'(cbig), exp_cnt(65535));
   endtask
   always @(negedge clk_200) if (mon_en) check_all("cyc");
   task automatic async_pulse();
      @(negedge clk_200);
      #1 sys_rst_i = 1'b1;
      #0.5 check_all("async");
      check("async_rst16", int'(r16), 1);
      check("async_cnt16", int'(c16), 0);
      @(negedge clk_200);
      sys_rst_i = 1'b0;
   endtask
   initial begin
      int k, k16, k1;
      #1 sys_rst_i = 1'b1;
      mmcm_locked = 1'b1;
      #1 mon_en = 1'b1;
      repeat (10) @(negedge clk_200);
      check("reset_rst16", int'(r16), 1);
      check("reset_cnt16", int'(c16), 0);
      mmcm_locked = 1'b0;
      repeat (3) @(negedge clk_200);
      sys_rst_i = 1'b0;
      repeat (4) @(negedge clk_200);
      // release latency: first sampling edge e, fall after edge e+1+N
      mmcm_locked = 1'b1;
      @(posedge clk_200);
      k = 0; k16 = -1; k1 = -1;
      while (k < 60) begin
         @(posedge clk_200);
         #1 k++;
         if (r16 == 1'b0 && k16 < 0) k16 = k;
         if (r1 == 1'b0 && k1 < 0) k1 = k;
      end
      check("lat16", k16, 16 + 1);
      check("lat1", k1, 1 + 1);
      repeat (240) @(negedge clk_200);
      check("sat255_cnt", int'(c255), 255);
      check("sat255_rst", int'(r255), 0);
      check("sat16_cnt", int'(c16), 16);
      // one-cycle lock drop after release
      @(negedge clk_200);
      mmcm_locked = 1'b0;
      @(negedge clk_200);
      mmcm_locked = 1'b1;
      k = 0; k16 = -1; k1 = -1;
      while (k < 60) begin
         @(posedge clk_200);
         #1 k++;
         if (r16 == 1'b1 && k1 < 0) k1 = k;
         if (r16 == 1'b0 && k1 > 0 && k16 < 0) k16 = k;
      end
      check("loss16", k1, 2);
      check("requal16", k16, 18);
      // default params: 400-cycle lock never qualifies
      @(negedge clk_200);
      mmcm_locked = 1'b0;
      repeat (10) @(negedge clk_200);
      mmcm_locked = 1'b1;
      repeat (400) @(negedge clk_200);
      check("short_def_rst", int'(rdef), 1);
      mmcm_locked = 1'b0;
      repeat (3) @(negedge clk_200);
      check("short_def_cnt", int'(cdef), 0);
      // async reset in the middle of COUNT
      mmcm_locked = 1'b1;
      repeat (8) @(negedge clk_200);
      async_pulse();
      repeat (30) @(negedge clk_200);
      for (int s = 0; s < 80; s++) begin
         mmcm_locked = 1'b1;
         repeat ($urandom_range(0, 40)) @(negedge clk_200);
         if ($urandom_range(0, 9) == 0) async_pulse();
         mmcm_locked = 1'b0;
         repeat ($urandom_range(1, 3)) @(negedge clk_200);
      end
      @(negedge clk_200);
      mon_en = 1'b0;
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
